uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive buffer directly downstream of the UART receiver. Drains each byte the receiver
//  holds (full/dout/re handshake) into a DEPTH-entry first-word-fall-through FIFO read by
//  the CPU/bus side. Reports fill level, sticky overrun and a threshold interrupt, so
//  software can service bursts without polling per byte.
// PARAMETERS
//  DEPTH      16  FIFO entries; power of two, >= 2. localparam AW = $clog2(DEPTH).
//  THRESHOLD  8   irq asserts while count >= THRESHOLD; range 1..DEPTH.
// PORTS
//  clk          in   1     single clock, all logic posedge
//  rst          in   1     synchronous, active-high reset
//  rx_full      in   1     receiver holding a byte
//  rx_data      in   8     receiver byte; valid while rx_full
//  rx_re        out  1     pop receiver; combinational, single-cycle
//  rd_en        in   1     consumer pops head entry
//  rd_data      out  8     head entry (FWFT); 8'h00 when empty
//  empty        out  1     FIFO has no entries
//  count        out  AW+1  entries held, 0..DEPTH
//  overrun      out  1     sticky: receiver byte was blocked by a full FIFO
//  clr_overrun  in   1     clears overrun
//  irq          out  1     count >= THRESHOLD
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, overrun=0. Outputs then: empty=1,
//    rd_data=0, irq=0, count=0. rx_re=0 while rst=1. Mid-operation reset discards contents.
//    Memory array not reset.
//  - push = rx_full && (count<DEPTH || pop). rx_re = push, combinational, same cycle.
//    Byte written to mem[wr_ptr] at that edge. Receiver drops full on the same edge, so
//    each byte is taken exactly once. No registered re; a registered re double-writes.
//  - pop = rd_en && count!=0. rd_en while empty is ignored; no state change.
//  - rd_data = mem[rd_ptr] combinationally when count!=0. Head is visible the cycle after
//    its push edge (write-to-read latency 1). No empty-FIFO bypass.
//  - Pointers AW bits, wrap DEPTH-1 -> 0 naturally. count: +1 on push only, -1 on pop only,
//    unchanged on push&&pop. Full + push + pop allowed: count stays DEPTH.
//  - Empty: push && rd_en same cycle -> push only (pop ignored), count 0->1.
//  - overrun <= 1 on any cycle with rx_full && count==DEPTH && !pop. The receiver stays
//    blocked and line data may be lost.
//  - clr_overrun clears overrun. A set condition in the same cycle wins (set priority).
//  - irq, empty: combinational from the count register. No extra latency.
// STRUCTURE
//  - uart_defs.vh (shared with uart_rx/uart_tx): `UART_DATA_W 8.
//  - One sub-module: sync_fifo_fwft (DATA_W, DEPTH).
//    Owns mem, pointers, count, FWFT read and push/pop arithmetic.
//    Exposes push, pop, full, empty, count, head.
//  - uart_rx_fifo wraps it. Adds rx_re gating, overrun flag, irq compare and the
//    rd_data zeroing when empty.
// TESTING
//  1 Reset: after rst, expect empty=1, count=0, rd_data=0, irq=0, overrun=0, rx_re=0.
//  2 Single byte: rx_full=1, rx_data=8'hA5 for 1 cycle.
//    Expect rx_re=1 that cycle; next cycle count=1, empty=0, rd_data=A5.
//    Then rd_en 1 cycle: empty=1, rd_data=0.
//  3 Fill/wrap: push 0x00..0x0F (DEPTH=16).
//    Expect count=16 and irq rising when count reaches 8.
//    Pop 4, push 0x10..0x13: pops yield 00..03, then 04..13 in order (pointer wrap).
//  4 Full backpressure: FIFO full, rx_full=1 held 3 cycles.
//    Expect rx_re=0 and overrun=1 from the next cycle; count=16.
//    Then rd_en 1 cycle: rx_re=1, count stays 16.
//  5 Simultaneous: count=5, push & rd_en same cycle -> count=5, head advances.
//    Empty, push & rd_en -> count=1, byte retained.
//  6 Clear/reset: overrun=1, clr_overrun -> 0.
//    clr_overrun with the set condition active -> overrun stays 1.
//    rst with count=7 -> empty next cycle; the old byte never reappears.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive-buffer path: byte width and FIFO op encoding.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  // {push, pop} as seen by the FIFO in one cycle.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: storage, pointers, occupancy count.
// Callers must only push when not full (or when popping) and only pop when not empty.
module sync_fifo_fwft
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DATA_W-1:0]          head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  fifo_op_e          w_op;

  assign w_op = fifo_op_e'({push, pop});

  // NOTE: storage has no reset; the count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case (w_op)
        OP_PUSH: r_count <= r_count + (AW+1)'(1);
        OP_POP:  r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign full  = (r_count == FULL_COUNT);
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: drains the receiver into a FWFT FIFO, flags overrun and raises
// a level interrupt once the fill level reaches THRESHOLD.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_full,
  input  logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_re,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  input  logic                   clr_overrun,
  output logic                   irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] IRQ_LEVEL = THRESHOLD[AW:0];

  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_count;
  uart_byte_t  w_head;
  logic        r_overrun;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte then.
  assign w_pop  = rd_en && !w_empty;
  assign w_push = rx_full && !rst && (!w_full || w_pop);

  sync_fifo_fwft #(
    .DATA_W (UART_DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (rx_data),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (w_head)
  );

  // Set wins over clear so a blocked byte is never silently forgotten.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (rx_full && w_full && !w_pop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign rx_re   = w_push;
  assign rd_data = w_empty ? '0 : w_head;
  assign empty   = w_empty;
  assign count   = w_count;
  assign overrun = r_overrun;
  assign irq     = (w_count >= IRQ_LEVEL);

endmodule
